// File: rtl/attn_stream_ctrl_if.sv
// Valid/ready element stream with end-of-frame marker.
// Latency: none (wires only).
// Backpressure: producer holds valid/data/last until a cycle with valid && ready.
//
// Ports (modports):
//   master : drives valid, data, last; samples ready
//   slave  : samples valid, data, last; drives ready
interface attn_stream_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                         valid;
  logic                         ready;
  logic signed [DATA_WIDTH-1:0] data;
  logic                         last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/attn_stream_ctrl.sv
// Host-side driver for the attention core: unpacks a load frame into parallel arrays, starts the core, streams the result.
// Latency: attn_start 1 cycle after the final load handshake; m_valid 1 cycle after attn_done.
// Backpressure: s_ready is low outside IDLE/LOAD; m_ready low holds m_data/m_last with no advance.
//
// Ports: clk, rst (async, active-low); s_if load stream (slave); m_if result stream (master);
//   mat_in / *_wt / *_bs arrays to the core; attn_start pulse, attn_done + attn_out from the core;
//   busy (not IDLE), err (sticky frame/timeout error, cleared by the next frame's first element).
// Optional feature: define ATTN_CTRL_TIMEOUT_EN to add a WAIT watchdog of TIMEOUT_CYCLES cycles.
module attn_stream_ctrl #(
  parameter int MATRIX_SIZE    = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int WT_CNT         = MATRIX_SIZE * MATRIX_SIZE,
  parameter int BS_CNT         = MATRIX_SIZE,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  attn_stream_ctrl_if.slave            s_if,
  attn_stream_ctrl_if.master           m_if,
  output logic signed [DATA_WIDTH-1:0] mat_in     [MATRIX_SIZE][MATRIX_SIZE],
  output logic signed [DATA_WIDTH-1:0] queries_wt [WT_CNT],
  output logic signed [DATA_WIDTH-1:0] queries_bs [BS_CNT],
  output logic signed [DATA_WIDTH-1:0] keys_wt    [WT_CNT],
  output logic signed [DATA_WIDTH-1:0] keys_bs    [BS_CNT],
  output logic signed [DATA_WIDTH-1:0] values_wt  [WT_CNT],
  output logic signed [DATA_WIDTH-1:0] values_bs  [BS_CNT],
  output logic signed [DATA_WIDTH-1:0] final_wt   [WT_CNT],
  output logic signed [DATA_WIDTH-1:0] final_bs   [BS_CNT],
  output logic                         attn_start,
  input  logic                         attn_done,
  input  logic signed [DATA_WIDTH-1:0] attn_out   [MATRIX_SIZE][MATRIX_SIZE],
  output logic                         busy,
  output logic                         err
);
  localparam int MS        = MATRIX_SIZE;
  localparam int CW        = $clog2(MS);
  localparam int WW        = $clog2(WT_CNT);
  localparam int BW        = $clog2(BS_CNT);
  localparam int FRAME_LEN = MS * MS + 4 * (WT_CNT + BS_CNT);
  localparam int IW        = $clog2(FRAME_LEN);

  typedef logic [IW-1:0] idx_t;

  // Start offset of each section inside the load frame.
  localparam idx_t B_QWT    = idx_t'(MS * MS);
  localparam idx_t B_QBS    = B_QWT + idx_t'(WT_CNT);
  localparam idx_t B_KWT    = B_QBS + idx_t'(BS_CNT);
  localparam idx_t B_KBS    = B_KWT + idx_t'(WT_CNT);
  localparam idx_t B_VWT    = B_KBS + idx_t'(BS_CNT);
  localparam idx_t B_VBS    = B_VWT + idx_t'(WT_CNT);
  localparam idx_t B_FWT    = B_VBS + idx_t'(BS_CNT);
  localparam idx_t B_FBS    = B_FWT + idx_t'(WT_CNT);
  localparam idx_t IDX_LAST = idx_t'(FRAME_LEN - 1);

  localparam logic [CW-1:0] RC_LAST = CW'(MS - 1);

  // Row/col of mat_in are sliced straight out of the section offset, so the
  // matrix must be square with a power-of-two side.
  if (WT_CNT != MS * MS || BS_CNT != MS || (1 << CW) != MS) begin : g_bad_size
    $error("attn_stream_ctrl: MATRIX_SIZE must be a power of two with WT_CNT=MS*MS, BS_CNT=MS");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 8191) begin : g_bad_timeout
    $error("attn_stream_ctrl: TIMEOUT_CYCLES must fit the 13-bit watchdog");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_STREAM} state_e;
  typedef enum logic [3:0] {SEG_MAT, SEG_QWT, SEG_QBS, SEG_KWT, SEG_KBS,
                            SEG_VWT, SEG_VBS, SEG_FWT, SEG_FBS} seg_e;

  state_e                       state_q, state_d;
  idx_t                         idx;
  seg_e                         seg;
  idx_t                         base;
  logic [WW-1:0]                off_wt;
  logic [BW-1:0]                off_bs;
  logic [CW-1:0]                row, col;
  logic signed [DATA_WIDTH-1:0] res_buf [MS][MS];
  logic                         s_hs, m_hs, m_last_i, cap, to_hit;

  assign s_hs     = s_if.valid && s_if.ready;
  assign m_hs     = m_if.valid && m_if.ready;
  assign m_last_i = (state_q == S_STREAM) && (row == RC_LAST) && (col == RC_LAST);

  // Decode which array the current frame index lands in.
  always_comb begin
    seg  = SEG_FBS;
    base = B_FBS;
    if      (idx < B_QWT) begin seg = SEG_MAT; base = '0;    end
    else if (idx < B_QBS) begin seg = SEG_QWT; base = B_QWT; end
    else if (idx < B_KWT) begin seg = SEG_QBS; base = B_QBS; end
    else if (idx < B_KBS) begin seg = SEG_KWT; base = B_KWT; end
    else if (idx < B_VWT) begin seg = SEG_KBS; base = B_KBS; end
    else if (idx < B_VBS) begin seg = SEG_VWT; base = B_VWT; end
    else if (idx < B_FWT) begin seg = SEG_VBS; base = B_VBS; end
    else if (idx < B_FBS) begin seg = SEG_FWT; base = B_FWT; end
  end

  assign off_wt = WW'(idx - base);
  assign off_bs = BW'(idx - base);

`ifdef ATTN_CTRL_TIMEOUT_EN
  localparam logic [12:0] TO_LAST = 13'(TIMEOUT_CYCLES - 1);
  logic [12:0] wait_cnt;

  // Zeroed in START so it reads 0 on the first WAIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    wait_cnt <= '0;
    else if (state_q == S_START) wait_cnt <= '0;
    else if (state_q == S_WAIT)  wait_cnt <= wait_cnt + 13'd1;
  end

  assign to_hit = (state_q == S_WAIT) && !attn_done && (wait_cnt == TO_LAST);
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cap         = 1'b0;
    attn_start  = 1'b0;
    busy        = (state_q != S_IDLE);
    // Held low while reset is asserted so every output reads 0 in reset.
    s_if.ready  = rst && ((state_q == S_IDLE) || (state_q == S_LOAD));
    m_if.valid  = (state_q == S_STREAM);
    m_if.data   = res_buf[row][col];
    m_if.last   = m_last_i;
    case (state_q)
      S_IDLE:   if (s_hs && !s_if.last) state_d = S_LOAD;
      S_LOAD:   if (s_hs) begin
                  if (idx == IDX_LAST)  state_d = S_START;
                  else if (s_if.last)   state_d = S_IDLE;
                end
      S_START:  begin
                  attn_start = 1'b1;
                  state_d    = S_WAIT;
                end
      S_WAIT:   if (attn_done) begin
                  cap     = 1'b1;
                  state_d = S_STREAM;
                end else if (to_hit) begin
                  state_d = S_IDLE;
                end
      S_STREAM: if (m_hs && m_last_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Frame index, error flag and result-stream position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
      err <= 1'b0;
      row <= '0;
      col <= '0;
    end else begin
      if (s_hs) begin
        if (state_q == S_IDLE) err <= 1'b0;
        if (idx == IDX_LAST) begin
          idx <= '0;
          if (!s_if.last) err <= 1'b1;
        end else if (s_if.last) begin
          // Short frame: drop it; partial array contents are left in place.
          idx <= '0;
          err <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
      if (to_hit) err <= 1'b1;
      if (m_hs) begin
        if (m_last_i) begin
          row <= '0;
          col <= '0;
        end else if (col == RC_LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Parameter arrays and result capture buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MS; i++) begin
        for (int j = 0; j < MS; j++) begin
          mat_in[i][j]  <= '0;
          res_buf[i][j] <= '0;
        end
      end
      for (int i = 0; i < WT_CNT; i++) begin
        queries_wt[i] <= '0;
        keys_wt[i]    <= '0;
        values_wt[i]  <= '0;
        final_wt[i]   <= '0;
      end
      for (int i = 0; i < BS_CNT; i++) begin
        queries_bs[i] <= '0;
        keys_bs[i]    <= '0;
        values_bs[i]  <= '0;
        final_bs[i]   <= '0;
      end
    end else begin
      if (s_hs) begin
        case (seg)
          SEG_MAT: mat_in[off_wt[WW-1:CW]][off_wt[CW-1:0]] <= s_if.data;
          SEG_QWT: queries_wt[off_wt] <= s_if.data;
          SEG_QBS: queries_bs[off_bs] <= s_if.data;
          SEG_KWT: keys_wt[off_wt]    <= s_if.data;
          SEG_KBS: keys_bs[off_bs]    <= s_if.data;
          SEG_VWT: values_wt[off_wt]  <= s_if.data;
          SEG_VBS: values_bs[off_bs]  <= s_if.data;
          SEG_FWT: final_wt[off_wt]   <= s_if.data;
          SEG_FBS: final_bs[off_bs]   <= s_if.data;
          default: ;
        endcase
      end
      if (cap) begin
        for (int i = 0; i < MS; i++) begin
          for (int j = 0; j < MS; j++) res_buf[i][j] <= attn_out[i][j];
        end
      end
    end
  end
endmodule
